// File: rtl/simplez_pkg.sv
// Shared Simplez definitions: screen peripheral I/O addresses, status bit
// positions, screen transmitter FSM encoding and the CPU opcode values.
// No ports; imported with `import simplez_pkg::*;`.
package simplez_pkg;

  // Memory-mapped screen registers at the top of the 9-bit address space
  localparam logic [8:0] ADDR_SCR_STATUS = 9'd508;
  localparam logic [8:0] ADDR_SCR_DATA   = 9'd509;

  // Bit positions inside the screen status word
  localparam int READY   = 0;
  localparam int BUSY    = 1;
  localparam int OVERRUN = 2;

  typedef enum logic [1:0] {
    SCR_IDLE  = 2'd0,
    SCR_START = 2'd1,
    SCR_DATA  = 2'd2,
    SCR_STOP  = 2'd3
  } scr_state_t;

  // Simplez instruction opcodes (CO field)
  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

endpackage

// File: rtl/simplez_baud_gen.sv
// Baud-rate tick generator for the screen UART.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   en   - count enable; while low the counter is held at 0
//   tick - one-cycle pulse in the last cycle of each bit period
module simplez_baud_gen #(
  parameter int DIVISOR = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;

  // Holding at 0 while disabled means every frame starts with a full bit.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/simplez_screen_tx.sv
// Simplez memory-mapped screen peripheral: bytes stored to address 509 are
// sent as UART 8N1; address 508 returns a status word (ready/busy/overrun).
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   addr      - CPU address bus
//   rd, wr    - read / write strobes
//   data_in   - CPU write data (only bits 7:0 are transmitted)
//   data_out  - registered read data, updated on every rd edge
//   hit       - combinational decode of 508/509 for the bus read mux
//   tx        - UART serial output, idles high
module simplez_screen_tx
  import simplez_pkg::*;
#(
  parameter int DATAW   = 12,
  parameter int ADDRW   = 9,
  parameter int DIVISOR = 104
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic             rd,
  input  logic             wr,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             hit,
  output logic             tx
);

  scr_state_t       r_state;
  logic [7:0]       r_hold;
  logic [7:0]       r_shift;
  logic             r_full;
  logic             r_ovr;
  logic             r_tx;
  logic [2:0]       r_bit;
  logic [DATAW-1:0] r_dout;

  logic             w_tick;
  logic             w_busy;
  logic             w_sel_stat;
  logic             w_sel_data;
  logic             w_xfer;
  logic             w_wr_data;
  logic             w_accept;
  logic [DATAW-1:0] w_status;
  logic             w_unused;

  assign w_sel_stat = (addr == ADDRW'(ADDR_SCR_STATUS));
  assign w_sel_data = (addr == ADDRW'(ADDR_SCR_DATA));
  assign w_busy     = (r_state != SCR_IDLE);

  // Holding register moves into the shifter when idle, or at the end of a
  // stop bit so back-to-back frames have no idle gap.
  assign w_xfer    = r_full && (!w_busy || (r_state == SCR_STOP && w_tick));
  assign w_wr_data = wr && w_sel_data;
  // A write landing on the transfer cycle is accepted: the slot frees up.
  assign w_accept  = w_wr_data && (!r_full || w_xfer);

  // Upper data bits have no meaning for an 8-bit serial character.
  assign w_unused  = ^data_in[DATAW-1:8];

  always_comb begin
    w_status          = '0;
    w_status[READY]   = !r_full;
    w_status[BUSY]    = w_busy;
    w_status[OVERRUN] = r_ovr;
  end

  simplez_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (w_busy),
    .tick (w_tick)
  );

  // Holding-register occupancy and overrun flag; a new overrun beats a
  // status-read clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_full <= 1'b1;
      end else if (w_xfer) begin
        r_full <= 1'b0;
      end
      if (w_wr_data && !w_accept) begin
        r_ovr <= 1'b1;
      end else if (rd && w_sel_stat) begin
        r_ovr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= data_in[7:0];
    end
    if (w_xfer) begin
      r_shift <= r_hold;
    end
  end

  // Read data register; only the status address returns non-zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (rd) begin
      r_dout <= w_sel_stat ? w_status : '0;
    end
  end

  // Transmit FSM; tx is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCR_IDLE;
      r_tx    <= 1'b1;
      r_bit   <= 3'd0;
    end else begin
      case (r_state)
        SCR_IDLE: begin
          if (w_xfer) begin
            r_state <= SCR_START;
            r_tx    <= 1'b0;
          end
        end
        SCR_START: begin
          if (w_tick) begin
            r_state <= SCR_DATA;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
          end
        end
        SCR_DATA: begin
          if (w_tick) begin
            if (r_bit == 3'd7) begin
              r_state <= SCR_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[r_bit + 3'd1];
            end
          end
        end
        SCR_STOP: begin
          if (w_tick) begin
            if (w_xfer) begin
              r_state <= SCR_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= SCR_IDLE;
              r_tx    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= SCR_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign data_out = r_dout;
  assign hit      = w_sel_stat || w_sel_data;
  assign tx       = r_tx;

endmodule

// File: tb/tb_simplez_screen_tx.sv
module tb_simplez_screen_tx;

  localparam int DATAW = 12;
  localparam int ADDRW = 9;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rd = 1'b0;
  logic             wr = 1'b0;
  logic [ADDRW-1:0] addr = '0;
  logic [DATAW-1:0] data_in = '0;
  logic [DATAW-1:0] data_out;
  logic             hit;
  logic             tx;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stop_bad = 0;
  int rx_q[$];
  int start_q[$];

  simplez_screen_tx #(.DATAW(DATAW), .ADDRW(ADDRW), .DIVISOR(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .data_in  (data_in),
    .data_out (data_out),
    .hit      (hit),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // UART receiver: j counts negedges since the first low sample of a frame.
  initial begin : mon
    int j;
    logic [7:0] sh;
    j = -1;
    sh = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        j = -1;
      end else if (j < 0) begin
        if (tx == 1'b0) begin
          j = 0;
          start_q.push_back(cyc);
        end
      end else begin
        j++;
        if (j >= 6 && j <= 34 && ((j - 6) % DIV) == 0) sh[(j - 6) / DIV] = tx;
        if (j == 38) begin
          if (tx !== 1'b1) stop_bad++;
          rx_q.push_back(int'(sh));
          j = -1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    addr = a;
    data_in = d;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [ADDRW-1:0] a);
    addr = a;
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  function automatic int qget(int k);
    if (k < rx_q.size()) return rx_q[k];
    return -1;
  endfunction

  function automatic logic exp_tx(int i, logic [7:0] b);
    if (i <= 4) return 1'b0;
    if (i <= 36) return b[(i - 5) / 4];
    return 1'b1;
  endfunction

  initial begin
    logic bad;
    int t0;

    // Reset, then idle line
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    rd_reg(9'd508);
    chk("idle_stat", 32'(data_out), 32'h001);
    bad = 1'b0;
    repeat (50) begin
      tick();
      if (tx !== 1'b1) bad = 1'b1;
    end
    chk("idle_tx", 32'(bad), 32'h0);

    // Single byte 0x55 (upper data bits ignored), cycle-exact waveform
    wr_reg(9'd509, 12'hF55);
    for (int i = 1; i <= 44; i++) begin
      if (i == 2) begin
        addr = 9'd508;
        rd = 1'b1;
      end
      tick();
      rd = 1'b0;
      if (i == 2) chk("busy_stat", 32'(data_out), 32'h003);
      chk($sformatf("byte_tx_%0d", i), 32'(tx), 32'(exp_tx(i, 8'h55)));
    end
    rd_reg(9'd508);
    chk("after_stat", 32'(data_out), 32'h001);

    // Back-to-back frames
    rx_q.delete();
    start_q.delete();
    wr_reg(9'd509, 12'h041);
    tick();
    wr_reg(9'd509, 12'h042);
    rd_reg(9'd508);
    chk("b2b_stat", 32'(data_out), 32'h002);
    repeat (90) tick();
    chk("b2b_n", 32'(rx_q.size()), 32'd2);
    chk("b2b_b0", 32'(qget(0)), 32'h41);
    chk("b2b_b1", 32'(qget(1)), 32'h42);
    t0 = (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : -1;
    chk("b2b_gap", 32'(t0), 32'd40);

    // Overrun on three consecutive writes
    rx_q.delete();
    start_q.delete();
    addr = 9'd509;
    wr = 1'b1;
    data_in = 12'h011;
    tick();
    data_in = 12'h022;
    tick();
    data_in = 12'h033;
    tick();
    wr = 1'b0;
    rd_reg(9'd508);
    chk("ovr_set", 32'(data_out), 32'h006);
    rd_reg(9'd508);
    chk("ovr_clr", 32'(data_out), 32'h002);
    repeat (100) tick();
    chk("ovr_n", 32'(rx_q.size()), 32'd2);
    chk("ovr_b0", 32'(qget(0)), 32'h11);
    chk("ovr_b1", 32'(qget(1)), 32'h22);

    // Address decode
    rx_q.delete();
    start_q.delete();
    addr = 9'd507; #1 chk("hit_507", 32'(hit), 32'h0);
    addr = 9'd508; #1 chk("hit_508", 32'(hit), 32'h1);
    addr = 9'd509; #1 chk("hit_509", 32'(hit), 32'h1);
    addr = 9'd510; #1 chk("hit_510", 32'(hit), 32'h0);
    wr_reg(9'd507, 12'h0FF);
    wr_reg(9'd510, 12'h0FF);
    wr_reg(9'd508, 12'h0FF);
    repeat (20) tick();
    chk("dec_nostart", 32'(start_q.size()), 32'd0);
    rd_reg(9'd508);
    chk("dec_stat", 32'(data_out), 32'h001);
    rd_reg(9'd509);
    chk("dec_rd509", 32'(data_out), 32'h000);

    // Reset during data bit 3 of 0xA5 (bit 3 = 0)
    wr_reg(9'd509, 12'h0A5);
    repeat (17) tick();
    chk("pre_rst_tx", 32'(tx), 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx", 32'(tx), 32'h1);
    rst = 1'b0;
    rd_reg(9'd508);
    chk("mid_rst_stat", 32'(data_out), 32'h001);
    chk("mid_rst_tx2", 32'(tx), 32'h1);
    rx_q.delete();
    start_q.delete();
    wr_reg(9'd509, 12'h03C);
    repeat (45) tick();
    chk("post_rst_n", 32'(rx_q.size()), 32'd1);
    chk("post_rst_b0", 32'(qget(0)), 32'h3C);
    chk("stop_bits", 32'(stop_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/simplez_screen_tx.md
Name: simplez_screen_tx

Overview:
- Memory-mapped "screen" output peripheral for the Simplez microcontroller.
- Sits on the CPU data/address bus beside main memory and consumes ST (store) cycles aimed at the Simplez I/O addresses 508 (status) and 509 (data).
- Bytes written to 509 are serialised as UART 8N1 on a tx pin.
- The CPU polls 508 with LD to see whether a new byte can be accepted.

Parameters:
- DATAW, 12, data bus width; matches CPU AC/RI width.
- ADDRW, 9, address bus width; matches CPU RA/CP width.
- DIVISOR, 104, clk cycles per UART bit; 12 MHz / 115200 baud.

Ports:
- clk  in  1  system clock; all registers update on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDRW  CPU address bus (RA).
- rd  in  1  read strobe (lec).
- wr  in  1  write strobe (esc).
- data_in  in  DATAW  CPU write data.
- data_out  out  DATAW  registered read data, valid one cycle after rd.
- hit  out  1  combinational; 1 when addr is 508 or 509, used by the top level to mux data_out over memory.
- tx  out  1  UART serial output, idles 1.

Behaviour:
- Reset (rst=1 at an edge):
  - tx=1, data_out=0, state IDLE.
  - Holding register empty, overrun=0, baud counter=0.
  - Reset mid-frame aborts the frame; tx is 1 from the reset edge.
- Status word (read at 508): bit0 ready = holding empty; bit1 busy = state!=IDLE; bit2 overrun; bits 11:3 = 0.
- Reads:
  - rd=1 and addr=508 at edge N → data_out=status word (sampled before edge N updates) from edge N.
  - The same read clears overrun at edge N.
  - rd=1 and addr=509 → data_out=0.
  - rd=1 with any other address → data_out=0.
  - data_out holds its value until the next rd edge.
- Writes:
  - wr=1 and addr=509 with holding empty → holding<=data_in[7:0] at edge N; data_in[11:8] is ignored.
  - wr=1 and addr=509 with holding full → write dropped and overrun<=1.
  - Writes to 508 are ignored.
- Simultaneous events:
  - Overrun-set and status-read-clear in the same cycle → overrun=1; set wins.
  - Write to 509 in the same cycle the holding register transfers to the shifter → accepted, since holding counts as empty that cycle.
- FSM: IDLE → START → DATA → STOP → IDLE, or STOP → START directly if holding is full at the end of STOP.
  - IDLE: if holding full at edge M, load the shifter, clear holding, enter START, and zero the baud counter. tx=0 from edge M.
  - START: tx=0 for DIVISOR cycles, then DATA with bit index 0.
  - DATA: tx=shifter[index], LSB first. Each bit lasts DIVISOR cycles. After bit 7, go to STOP.
  - STOP: tx=1 for DIVISOR cycles. Then go to START if holding is full (same load rules as IDLE, no idle gap); otherwise go to IDLE.
- Timing: frame is exactly 10×DIVISOR cycles. Write-to-start-bit latency is 1 cycle when idle.
- Baud counter runs 0..DIVISOR-1 and wraps. A bit boundary occurs at the wrap. The counter is held at 0 in IDLE.

Decomposition:
- Shared package simplez_pkg:
  - ADDR_SCR_STATUS=9'd508, ADDR_SCR_DATA=9'd509.
  - Status bit indices READY=0, BUSY=1, OVERRUN=2.
  - Screen FSM state encoding (IDLE/START/DATA/STOP).
  - The Simplez opcode localparams (ST..HALT).
- Sub-module simplez_baud_gen (parameter DIVISOR; inputs clk, rst, en; output tick pulsing on the counter wrap). The remaining logic stays in this module.

Test Plan (bench uses DIVISOR=4):
- Reset then idle: rst high 2 cycles, release; read 508 → data_out=12'h001; tx stays 1 for 50 cycles.
- Single byte: write 12'hF55 to 509 at edge N.
  - tx=0 for edges N+1..N+4.
  - Then data bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - Then tx=1 for 4 cycles.
  - Read 508 at N+2 → 12'h003.
- Back-to-back: write 0x41, then 0x42 while the first is shifting.
  - Second frame's start bit begins immediately after the first stop bit (frames 40 cycles apart).
  - ready=0 between the second write and its transfer.
- Overrun: write 0x11, 0x22, 0x33 on consecutive writes.
  - 0x33 is dropped; read 508 → bit2=1.
  - Second read → bit2=0.
  - Only 0x11 and 0x22 appear on tx.
- Decode/hit: hit=1 only for addr 508/509.
  - Write to 507 and 510 → no tx activity.
  - Read 509 → 12'h000.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 from that edge, read 508 → 12'h001, and the next write produces a clean full frame.
